// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak sponge constants and FSM state encoding
package keccak_pkg;

    localparam int STATE_W = 1600;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        PERM    = 2'd2,
        SQUEEZE = 2'd3
    } sponge_state_e;

endpackage

// File: rtl/keccak_sponge_ctrl_if.sv
// rtl/keccak_sponge_ctrl_if.sv - absorb/squeeze/permutation handshake bundle of the sponge controller
interface keccak_sponge_ctrl_if
    import keccak_pkg::*;
#(
    parameter int RATE_W = 1088
) ();

    logic               start_i;
    logic               blk_valid_i;
    logic               blk_ready_o;
    logic [RATE_W-1:0]  blk_data_i;
    logic               blk_last_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [RATE_W-1:0]  out_data_o;
    logic               perm_start_o;
    logic [STATE_W-1:0] perm_state_o;
    logic               perm_ready_i;
    logic [STATE_W-1:0] perm_state_i;
    logic               busy_o;
    logic               done_o;

    // master is the sponge controller; slave is the integrating environment
    modport master (
        input  start_i, blk_valid_i, blk_data_i, blk_last_i,
        input  out_ready_i, perm_ready_i, perm_state_i,
        output blk_ready_o, out_valid_o, out_data_o,
        output perm_start_o, perm_state_o, busy_o, done_o
    );

    modport slave (
        output start_i, blk_valid_i, blk_data_i, blk_last_i,
        output out_ready_i, perm_ready_i, perm_state_i,
        input  blk_ready_o, out_valid_o, out_data_o,
        input  perm_start_o, perm_state_o, busy_o, done_o
    );

endinterface

// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - Keccak sponge sequencer: absorbs padded rate blocks, drives an external permutation, squeezes output blocks
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int RATE_W       = 1088,
    parameter int SQUEEZE_BLKS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    keccak_sponge_ctrl_if.master bus
);

    localparam int                CNT_W    = $clog2(SQUEEZE_BLKS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SQUEEZE_BLKS - 1);

    sponge_state_e      fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] absorb_d;
    logic [CNT_W-1:0]   sq_cnt;
    logic               last_q;
    logic               blk_ready_q;
    logic               out_valid_q;
    logic               perm_start_q;
    logic               busy_q;
    logic               done_q;

    // Only the rate portion takes the block; the capacity is never touched from outside.
    always_comb begin
        absorb_d               = state_q;
        absorb_d[RATE_W-1:0]   = state_q[RATE_W-1:0] ^ bus.blk_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q        <= IDLE;
            state_q      <= '0;
            sq_cnt       <= '0;
            last_q       <= 1'b0;
            blk_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            perm_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q     <= '0;
                        sq_cnt      <= '0;
                        last_q      <= 1'b0;
                        fsm_q       <= ABSORB;
                        blk_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ABSORB: begin
                    if (bus.blk_valid_i) begin
                        state_q      <= absorb_d;
                        last_q       <= bus.blk_last_i;
                        fsm_q        <= PERM;
                        blk_ready_q  <= 1'b0;
                        perm_start_q <= 1'b1;
                    end
                end
                PERM: begin
                    // Done may coincide with the start cycle; state_q is frozen until it arrives.
                    if (bus.perm_ready_i) begin
                        state_q <= bus.perm_state_i;
                        if (last_q) begin
                            fsm_q       <= SQUEEZE;
                            out_valid_q <= 1'b1;
                        end else begin
                            fsm_q       <= ABSORB;
                            blk_ready_q <= 1'b1;
                        end
                    end
                end
                SQUEEZE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (sq_cnt == LAST_CNT) begin
                            fsm_q  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            sq_cnt       <= sq_cnt + CNT_W'(1);
                            fsm_q        <= PERM;
                            perm_start_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    blk_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.blk_ready_o  = blk_ready_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = state_q[RATE_W-1:0];
    assign bus.perm_start_o = perm_start_q;
    assign bus.perm_state_o = state_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule

// File: doc/keccak_sponge_ctrl.md
KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

Interface
REQ-001 SHALL have parameter RATE_W, default 1088, meaning sponge rate in bits; legal range 8..1599, multiple of 8.
REQ-002 SHALL have parameter SQUEEZE_BLKS, default 1, meaning number of rate blocks emitted per message; legal range >= 1.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock, rising-edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, meaning begin a new message (pulse).
REQ-006 SHALL have ports blk_valid_i (input, 1), blk_ready_o (output, 1), blk_data_i (input, RATE_W), blk_last_i (input, 1), meaning the padded absorb block stream.
REQ-007 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, RATE_W), meaning the squeeze block stream.
REQ-008 SHALL have ports perm_start_o (output, 1), perm_state_o (output, 1600), perm_ready_i (input, 1), perm_state_i (input, 1600), meaning the permutation core: start pulse, state in, one-cycle done pulse, state out.
REQ-009 SHALL have ports busy_o (output, 1) and done_o (output, 1), meaning in-progress level and message-complete pulse.

Function
REQ-010 SHALL implement FSM states IDLE, ABSORB, PERM, SQUEEZE.
REQ-011 SHALL hold a 1600-bit state register state_q and a squeeze counter sq_cnt of width $clog2(SQUEEZE_BLKS+1).
REQ-012 IDLE: start_i=1 SHALL clear state_q and sq_cnt to 0, clear the last flag, and move to ABSORB next cycle; start_i in any other state SHALL be ignored.
REQ-013 blk_ready_o SHALL be 1 exactly when state is ABSORB; a handshake is blk_valid_i & blk_ready_o.
REQ-014 On absorb handshake: state_q[RATE_W-1:0] ^= blk_data_i, upper bits unchanged; blk_last_i is latched into the last flag; next state PERM.
REQ-015 perm_start_o SHALL be 1 for exactly the first cycle of every PERM visit; perm_state_o SHALL equal state_q and stay stable throughout PERM.
REQ-016 In PERM, perm_ready_i=1 SHALL load state_q from perm_state_i. Next state is ABSORB if the last flag is 0, otherwise SQUEEZE.
REQ-017 perm_ready_i outside PERM SHALL be ignored; perm_ready_i in the same cycle as perm_start_o SHALL be accepted.
REQ-018 SQUEEZE: out_valid_o=1 and out_data_o=state_q[RATE_W-1:0], both held stable until out_ready_i.
REQ-019 On squeeze handshake: if sq_cnt==SQUEEZE_BLKS-1, next state is IDLE and done_o=1 for one cycle (the IDLE entry cycle); otherwise sq_cnt increments and next state is PERM.
REQ-020 busy_o SHALL be 1 whenever state != IDLE.
REQ-021 Latency: start_i at cycle 0 gives blk_ready_o=1 at cycle 1. An absorb handshake at cycle t gives perm_start_o=1 at t+1. perm_ready_i at cycle p gives blk_ready_o or out_valid_o at p+1.
REQ-022 state_q SHALL be retained after done_o until the next accepted start_i.
REQ-023 The block SHALL not perform padding; padded input is the upstream contract.

Reset
REQ-024 rst_i=1 at a clock edge SHALL force IDLE and clear state_q, sq_cnt and the last flag, from any state including mid-PERM.
REQ-025 During and after reset, blk_ready_o, out_valid_o, perm_start_o, busy_o and done_o SHALL be 0; out_data_o and perm_state_o SHALL be 0.
REQ-026 A perm_ready_i arriving after a reset that aborted PERM SHALL be ignored (REQ-017).

Structure
REQ-027 STATE_W=1600 and the FSM state enum SHALL live in shared package keccak_pkg.
REQ-028 No sub-module SHALL be required. Connection to keccak_f is made by the integrating wrapper, outside this block.

Verification
REQ-029 start_i, then one all-zero block with blk_last_i=1, SQUEEZE_BLKS=1 -> one PERM; out_data_o[63:0]=64'hF1258F7940E1DDE7; done_o pulses once.
REQ-030 Three blocks with last on the third -> exactly 3 perm_start_o pulses before out_valid_o; each block is XORed into the low RATE_W bits only, checked against a reference model.
REQ-031 SQUEEZE_BLKS=3, out_ready_i held 0 for 5 cycles -> out_valid_o and out_data_o stable; the full message yields 2 extra perm_start_o pulses and 3 output blocks.
REQ-032 rst_i asserted in the middle of PERM, followed by a stray perm_ready_i -> FSM stays IDLE; state_q=0; no outputs asserted.
REQ-033 start_i pulsed during ABSORB and during SQUEEZE -> no effect on state_q or the FSM.
REQ-034 perm_ready_i in the same cycle as perm_start_o -> accepted; next cycle is ABSORB or SQUEEZE.
